fp_addsub_pipe: RTL and testbench
=================================

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, meaning stored fraction width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port CLK, input, 1: rising-edge clock for all state.
REQ-005 Port nRST, input, 1: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1: operands valid.
REQ-007 Port in_ready, output, 1: block can accept operands this cycle.
REQ-008 Port op_a, input, W: IEEE-754-style operand A.
REQ-009 Port op_b, input, W: IEEE-754-style operand B.
REQ-010 Port sub, input, 1: 1 = compute A-B, 0 = compute A+B.
REQ-011 Port out_valid, output, 1: result and flags valid.
REQ-012 Port out_ready, input, 1: downstream accepts result.
REQ-013 Port result, output, W: rounded sum/difference.
REQ-014 Port overflow, output, 1; underflow, output, 1; inexact, output, 1; invalid, output, 1: exception flags qualified by out_valid.

Function
REQ-015 SHALL be a 3-stage pipeline: S1 unpack, classify, swap so |big|>=|small|, align small with guard/round/sticky; S2 significand add/subtract (MAN_W+4 bits plus carry); S3 leading-zero normalise, round-to-nearest-even, pack, flags.
REQ-016 Operand transfer SHALL occur when in_valid && in_ready; result transfer when out_valid && out_ready.
REQ-017 Pipeline SHALL advance all stages together when !out_valid || out_ready; in_ready SHALL equal that advance condition (combinational).
REQ-018 Latency SHALL be exactly 3 cycles from transfer to out_valid with no stall; throughput one op per cycle.
REQ-019 While out_valid && !out_ready, result and all flags SHALL hold stable and no stage SHALL change.
REQ-020 Results SHALL emerge in acceptance order; no op dropped or duplicated; bubbles (in_valid low) SHALL propagate as invalid stage slots.
REQ-021 sub SHALL invert B's sign before S1; effective operation = sign(A) XOR sign(B') selects add or subtract.
REQ-022 Exponent field 0 SHALL mean subnormal: implicit bit 0, effective exponent 1; results below min normal SHALL be packed subnormal.
REQ-023 Alignment shifts >= MAN_W+3 SHALL collapse small significand into sticky only.
REQ-024 Exact cancellation SHALL give +0, except (-0)+(-0) and (-0)-(+0) give -0.
REQ-025 Any NaN input SHALL give canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0); sNaN input or inf-inf effective SHALL set invalid.
REQ-026 Inf op finite SHALL give that inf, flags 0.
REQ-027 Rounded exponent >= all-ones SHALL give signed inf with overflow=1, inexact=1.
REQ-028 inexact SHALL be 1 when any discarded bit is nonzero; underflow SHALL be 1 when result is tiny (subnormal/zero after rounding) and inexact.
REQ-029 Rounding carry out of fraction SHALL increment exponent (subnormal->normal, normal->next binade/overflow).

Reset
REQ-030 nRST low SHALL immediately clear all stage-valid bits; out_valid=0, result=0, all flags 0; in_ready=1 after release.
REQ-031 Reset mid-operation SHALL discard all in-flight ops; first transfer after release behaves as from idle.

Verification (defaults EXP_W=8, MAN_W=23)
REQ-032 0x3F800000 + 0x3F800000, sub=0, out_ready=1 -> out_valid 3 cycles later, result 0x40000000, flags 0.
REQ-033 0x3F800000 with 0x3F800000, sub=1 -> 0x00000000 flags 0; 0x80000000 + 0x80000000 -> 0x80000000.
REQ-034 0x3F800000 + 0x33800000 -> 0x3F800000 inexact=1 (tie to even); 0x3F800000 + 0x33800001 -> 0x3F800001 inexact=1.
REQ-035 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 overflow=1 inexact=1; 0x7F800000 + 0xFF800000 -> 0x7FC00000 invalid=1.
REQ-036 0x00000001 + 0x00000001 -> 0x00000002 flags 0; 0x00800000 - 0x00000001 -> 0x007FFFFF flags 0.
REQ-037 Four back-to-back ops, out_ready low 2 cycles after first out_valid -> in_ready low, result stable, all four results in order; nRST pulse mid-stream -> out_valid 0 immediately, no stale result afterwards.

Source files
------------

// File: rtl/fp_addsub_pipe_if.sv
// Handshake and data bundle for the pipelined floating-point adder/subtractor.
// The producer/consumer side uses master, the arithmetic block uses slave.
interface fp_addsub_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         underflow;
    logic         inexact;
    logic         invalid;

    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, inexact, invalid
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, result, overflow, underflow, inexact, invalid
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754-style add/subtract with round-to-nearest-even.
// Stage 1 unpacks and aligns, stage 2 adds significands, stage 3 normalises, rounds, packs.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic             CLK,
    input logic             nRST,
    fp_addsub_pipe_if.slave io
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;   // hidden bit, fraction, guard, round, sticky
    localparam int EW = EXP_W + 2;   // headroom so exponent overflow is visible
    localparam int RW = MAN_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic int lzc(input logic [SW-1:0] v);
        int n;
        n = SW;
        for (int i = 0; i < SW; i++) if (v[i]) n = SW - 1 - i;
        return n;
    endfunction

    logic advance;
    assign advance     = !io.out_valid || io.out_ready;
    assign io.in_ready = advance;

    // ---------------- stage 1: unpack, classify, swap, align ----------------
    logic             a_s, b_s;
    logic [EXP_W-1:0] a_e, b_e;
    logic [MAN_W-1:0] a_f, b_f;
    logic             a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, swap;
    logic             big_s, sml_s;
    logic [EXP_W-1:0] big_e, sml_e, big_ee, sml_ee, diff;
    logic [MAN_W-1:0] big_f, sml_f;
    logic [SW-1:0]    sml_sig, shifted;

    logic             s1_valid_d, s1_special_d, s1_spec_inv_d, s1_sign_d, s1_eff_sub_d;
    logic [W-1:0]     s1_spec_res_d;
    logic [EXP_W-1:0] s1_exp_d;
    logic [SW-1:0]    s1_big_d, s1_small_d;

    logic             s1_valid_q, s1_special_q, s1_spec_inv_q, s1_sign_q, s1_eff_sub_q;
    logic [W-1:0]     s1_spec_res_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [SW-1:0]    s1_big_q, s1_small_q;

    assign a_s = io.op_a[W-1];
    assign a_e = io.op_a[W-2:MAN_W];
    assign a_f = io.op_a[MAN_W-1:0];
    assign b_s = io.op_b[W-1] ^ io.sub;
    assign b_e = io.op_b[W-2:MAN_W];
    assign b_f = io.op_b[MAN_W-1:0];

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        a_nan  = (a_e == EXP_ONES) && (a_f != '0);
        b_nan  = (b_e == EXP_ONES) && (b_f != '0);
        a_inf  = (a_e == EXP_ONES) && (a_f == '0);
        b_inf  = (b_e == EXP_ONES) && (b_f == '0);
        a_snan = a_nan && !a_f[MAN_W-1];
        b_snan = b_nan && !b_f[MAN_W-1];

        swap   = io.op_b[W-2:0] > io.op_a[W-2:0];
        big_s  = swap ? b_s : a_s;
        sml_s  = swap ? a_s : b_s;
        big_e  = swap ? b_e : a_e;
        sml_e  = swap ? a_e : b_e;
        big_f  = swap ? b_f : a_f;
        sml_f  = swap ? a_f : b_f;
        big_ee = (big_e == '0) ? EXP_W'(1) : big_e;
        sml_ee = (sml_e == '0) ? EXP_W'(1) : sml_e;
        diff   = big_ee - sml_ee;

        sml_sig = {sml_e != '0, sml_f, 3'b000};
        shifted = sml_sig >> diff;
        if ({{(32-EXP_W){1'b0}}, diff} >= 32'(MAN_W + 3))
            s1_small_d = {{(SW-1){1'b0}}, |sml_sig};
        else
            s1_small_d = {shifted[SW-1:1],
                          shifted[0] | (|(sml_sig & ~({SW{1'b1}} << diff)))};

        s1_valid_d    = io.in_valid;
        s1_big_d      = {big_e != '0, big_f, 3'b000};
        s1_exp_d      = big_ee;
        s1_sign_d     = big_s;
        s1_eff_sub_d  = big_s ^ sml_s;
        s1_special_d  = a_nan || b_nan || a_inf || b_inf;
        s1_spec_inv_d = 1'b0;
        if (a_nan || b_nan) begin
            s1_spec_res_d = QNAN;
            s1_spec_inv_d = a_snan || b_snan;
        end else if (a_inf && b_inf && (a_s != b_s)) begin
            s1_spec_res_d = QNAN;
            s1_spec_inv_d = 1'b1;
        end else if (a_inf) begin
            s1_spec_res_d = {a_s, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            s1_spec_res_d = {b_s, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    // ---------------- stage 2: significand add/subtract ----------------
    logic             s2_valid_d, s2_special_d, s2_spec_inv_d, s2_sign_d, s2_zero_sign_d;
    logic [W-1:0]     s2_spec_res_d;
    logic [EXP_W-1:0] s2_exp_d;
    logic [SW:0]      s2_sum_d;

    logic             s2_valid_q, s2_special_q, s2_spec_inv_q, s2_sign_q, s2_zero_sign_q;
    logic [W-1:0]     s2_spec_res_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [SW:0]      s2_sum_q;

    always_comb begin
        s2_valid_d     = s1_valid_q;
        s2_special_d   = s1_special_q;
        s2_spec_res_d  = s1_spec_res_q;
        s2_spec_inv_d  = s1_spec_inv_q;
        s2_sign_d      = s1_sign_q;
        s2_exp_d       = s1_exp_q;
        // Exact cancellation rounds to +0; same-sign zeros keep their sign.
        s2_zero_sign_d = s1_eff_sub_q ? 1'b0 : s1_sign_q;
        if (s1_eff_sub_q) s2_sum_d = {1'b0, s1_big_q} - {1'b0, s1_small_q};
        else              s2_sum_d = {1'b0, s1_big_q} + {1'b0, s1_small_q};
    end

    // ---------------- stage 3: normalise, round, pack ----------------
    logic          carry, round_up, rnd_carry, lost;
    int            lz, max_sh, sh;
    logic [SW-1:0] norm;
    logic [EW-1:0] e_norm, e_field, f_field;
    logic [MAN_W:0] mant;
    logic [RW-1:0]  rounded;

    logic         out_valid_d, overflow_d, underflow_d, inexact_d, invalid_d;
    logic [W-1:0] result_d;
    logic         out_valid_q, overflow_q, underflow_q, inexact_q, invalid_q;
    logic [W-1:0] result_q;

    always_comb begin
        carry  = s2_sum_q[SW];
        lz     = lzc(s2_sum_q[SW-1:0]);
        max_sh = 32'(s2_exp_q) - 1;
        // Never normalise below the minimum exponent; what remains is subnormal.
        sh     = (lz < max_sh) ? lz : max_sh;
        if (carry) begin
            norm   = {s2_sum_q[SW:2], s2_sum_q[1] | s2_sum_q[0]};
            e_norm = {2'b00, s2_exp_q} + EW'(1);
        end else begin
            norm   = s2_sum_q[SW-1:0] << sh;
            e_norm = {2'b00, s2_exp_q} - EW'(sh);
        end
        e_field   = norm[SW-1] ? e_norm : '0;
        mant      = norm[SW-1:3];
        lost      = |norm[2:0];
        round_up  = norm[2] && (norm[1] || norm[0] || mant[0]);
        rounded   = {1'b0, mant} + RW'(round_up);
        rnd_carry = norm[SW-1] ? rounded[MAN_W+1] : rounded[MAN_W];
        f_field   = e_field + EW'(rnd_carry);

        out_valid_d = s2_valid_q;
        result_d    = '0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        inexact_d   = 1'b0;
        invalid_d   = 1'b0;
        if (!s2_valid_q) begin
            result_d = '0;
        end else if (s2_special_q) begin
            result_d  = s2_spec_res_q;
            invalid_d = s2_spec_inv_q;
        end else if (s2_sum_q == '0) begin
            result_d = {s2_zero_sign_q, {(W-1){1'b0}}};
        end else if (f_field >= {2'b00, EXP_ONES}) begin
            result_d   = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            overflow_d = 1'b1;
            inexact_d  = 1'b1;
        end else begin
            result_d    = {s2_sign_q, f_field[EXP_W-1:0], rounded[MAN_W-1:0]};
            inexact_d   = lost;
            underflow_d = lost && (f_field == '0);
        end
    end

    // NOTE: non-blocking assignments make every stage sample the pre-edge value of the one before it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s1_valid_q     <= 1'b0;
            s1_special_q   <= 1'b0;
            s1_spec_inv_q  <= 1'b0;
            s1_sign_q      <= 1'b0;
            s1_eff_sub_q   <= 1'b0;
            s1_spec_res_q  <= '0;
            s1_exp_q       <= '0;
            s1_big_q       <= '0;
            s1_small_q     <= '0;
            s2_valid_q     <= 1'b0;
            s2_special_q   <= 1'b0;
            s2_spec_inv_q  <= 1'b0;
            s2_sign_q      <= 1'b0;
            s2_zero_sign_q <= 1'b0;
            s2_spec_res_q  <= '0;
            s2_exp_q       <= '0;
            s2_sum_q       <= '0;
            out_valid_q    <= 1'b0;
            result_q       <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            inexact_q      <= 1'b0;
            invalid_q      <= 1'b0;
        end else if (advance) begin
            s1_valid_q     <= s1_valid_d;
            s1_special_q   <= s1_special_d;
            s1_spec_inv_q  <= s1_spec_inv_d;
            s1_sign_q      <= s1_sign_d;
            s1_eff_sub_q   <= s1_eff_sub_d;
            s1_spec_res_q  <= s1_spec_res_d;
            s1_exp_q       <= s1_exp_d;
            s1_big_q       <= s1_big_d;
            s1_small_q     <= s1_small_d;
            s2_valid_q     <= s2_valid_d;
            s2_special_q   <= s2_special_d;
            s2_spec_inv_q  <= s2_spec_inv_d;
            s2_sign_q      <= s2_sign_d;
            s2_zero_sign_q <= s2_zero_sign_d;
            s2_spec_res_q  <= s2_spec_res_d;
            s2_exp_q       <= s2_exp_d;
            s2_sum_q       <= s2_sum_d;
            out_valid_q    <= out_valid_d;
            result_q       <= result_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            inexact_q      <= inexact_d;
            invalid_q      <= invalid_d;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.result    = result_q;
    assign io.overflow  = overflow_q;
    assign io.underflow = underflow_q;
    assign io.inexact   = inexact_q;
    assign io.invalid   = invalid_q;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe (single precision): reset, arithmetic, rounding,
// specials, subnormals, back-pressure ordering and mid-stream reset.
module tb_fp_addsub_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .io   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] flags_now();
        return {bus.overflow, bus.underflow, bus.inexact, bus.invalid};
    endfunction

    // Present one operation, then wait (bounded) for its result with out_ready held high.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] r, output logic [3:0] f, output int lat);
        @(negedge clk);
        bus.op_a      = a;
        bus.op_b      = b;
        bus.sub       = s;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = bus.result;
        f = flags_now();
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.sub       = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
        n_cmp++;
        if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h, expected 00000000", bus.result); end
        n_cmp++;
        if (flags_now() !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b, expected 0000", flags_now()); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
    endtask

    task automatic test_add_sub();
        logic [31:0] va[7], vb[7], vr[7];
        logic        vs[7];
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        va = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h80000000, 32'h3FC00000, 32'h40400000, 32'hBF800000};
        vb = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h00000000, 32'hC0200000, 32'h3F800000, 32'h3F800000};
        vs = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vr = '{32'h40000000, 32'h00000000, 32'h80000000, 32'h80000000, 32'hBF800000, 32'h40000000, 32'h00000000};
        for (int i = 0; i < 7; i++) begin
            do_op(va[i], vb[i], vs[i], r, f, lat);
            n_cmp++;
            if ({f, r} !== {4'b0000, vr[i]}) begin
                n_fail++;
                $display("FAIL add_sub[%0d]: got flags %b result %h, expected flags 0000 result %h", i, f, r, vr[i]);
            end
            n_cmp++;
            if (lat !== 3) begin n_fail++; $display("FAIL add_sub_latency[%0d]: got %0d, expected 3", i, lat); end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] va[5], vb[5], vr[5];
        logic        vs[5];
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        va = '{32'h3F800000, 32'h3F800000, 32'h3FFFFFFF, 32'h3F800000, 32'h3F800000};
        vb = '{32'h33800000, 32'h33800001, 32'h33800000, 32'h00000001, 32'h33000000};
        vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vr = '{32'h3F800000, 32'h3F800001, 32'h40000000, 32'h3F800000, 32'h3F800000};
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vs[i], r, f, lat);
            n_cmp++;
            if ({f, r} !== {4'b0010, vr[i]}) begin
                n_fail++;
                $display("FAIL rounding[%0d]: got flags %b result %h, expected flags 0010 result %h", i, f, r, vr[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] va[8], vb[8], vr[8];
        logic        vs[8];
        logic [3:0]  vf[8];
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        va = '{32'h7F7FFFFF, 32'h7F800000, 32'h7F800000, 32'h7FC00000,
               32'h7F800001, 32'hFF800000, 32'h3F800000, 32'h7F7FFFFF};
        vb = '{32'h7F7FFFFF, 32'hFF800000, 32'h7F800000, 32'h3F800000,
               32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h73000000};
        vs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vr = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
               32'h7FC00000, 32'hFF800000, 32'hFF800000, 32'h7F800000};
        vf = '{4'b1010, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b1010};
        for (int i = 0; i < 8; i++) begin
            do_op(va[i], vb[i], vs[i], r, f, lat);
            n_cmp++;
            if ({f, r} !== {vf[i], vr[i]}) begin
                n_fail++;
                $display("FAIL special[%0d]: got flags %b result %h, expected flags %b result %h", i, f, r, vf[i], vr[i]);
            end
        end
    endtask

    task automatic test_subnormal();
        logic [31:0] va[4], vb[4], vr[4];
        logic        vs[4];
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        va = '{32'h00000001, 32'h00800000, 32'h00400000, 32'h80000003};
        vb = '{32'h00000001, 32'h00000001, 32'h00400000, 32'h00000001};
        vs = '{1'b0, 1'b1, 1'b0, 1'b0};
        vr = '{32'h00000002, 32'h007FFFFF, 32'h00800000, 32'h80000002};
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vs[i], r, f, lat);
            n_cmp++;
            if ({f, r} !== {4'b0000, vr[i]}) begin
                n_fail++;
                $display("FAIL subnormal[%0d]: got flags %b result %h, expected flags 0000 result %h", i, f, r, vr[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va[4], vb[4], vr[4];
        logic        vs[4];
        int          idx_in, idx_out, stall, cyc;
        logic        stall_done;
        logic [35:0] held;
        va = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h40A00000};
        vb = '{32'h40000000, 32'h3F800000, 32'hC0200000, 32'h40400000};
        vs = '{1'b0, 1'b1, 1'b0, 1'b0};
        vr = '{32'h40400000, 32'h40000000, 32'hBF800000, 32'h41000000};
        idx_in = 0; idx_out = 0; stall = 0; cyc = 0; stall_done = 1'b0; held = '0;
        @(negedge clk);
        while (idx_out < 4 && cyc < 50) begin
            bus.in_valid = (idx_in < 4);
            if (idx_in < 4) begin
                bus.op_a = va[idx_in];
                bus.op_b = vb[idx_in];
                bus.sub  = vs[idx_in];
            end
            if (bus.out_valid && !stall_done) begin
                stall_done = 1'b1;
                stall      = 2;
                held       = {flags_now(), bus.result};
            end
            bus.out_ready = (stall == 0);
            #1;
            if (stall > 0) begin
                n_cmp++;
                if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b, expected 0", bus.in_ready); end
            end
            if (stall == 1) begin
                n_cmp++;
                if ({flags_now(), bus.result} !== held || bus.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid %b %h, expected valid 1 %h", bus.out_valid, {flags_now(), bus.result}, held);
                end
            end
            if (bus.in_valid && bus.in_ready) idx_in++;
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if ({flags_now(), bus.result} !== {4'b0000, vr[idx_out]}) begin
                    n_fail++;
                    $display("FAIL b2b_order[%0d]: got %h, expected %h", idx_out, {flags_now(), bus.result}, {4'b0000, vr[idx_out]});
                end
                idx_out++;
            end
            if (stall > 0) stall--;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (idx_out != 4) begin n_fail++; $display("FAIL b2b_count: got %0d results, expected 4", idx_out); end
    endtask

    task automatic test_reset_midstream();
        int          wait_cyc;
        logic        seen_valid;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op_a = 32'h3F800000; bus.op_b = 32'h3F800000; bus.sub = 1'b0;
        @(negedge clk);
        bus.op_a = 32'h40A00000; bus.op_b = 32'h40400000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_cyc = 0;
        while (!bus.out_valid && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_fill: got out_valid %b, expected 1", bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_now: got valid %b result %h, expected valid 0 result 00000000", bus.out_valid, bus.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid = 1'b1;
        end
        n_cmp++;
        if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got out_valid 1 after reset, expected 0"); end
        do_op(32'h3F800000, 32'h40000000, 1'b0, r, f, lat);
        n_cmp++;
        if ({f, r} !== {4'b0000, 32'h40400000} || lat !== 3) begin
            n_fail++;
            $display("FAIL mid_restart: got flags %b result %h latency %0d, expected 0000 40400000 3", f, r, lat);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_rounding();
        test_special();
        test_subnormal();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
